// File: rtl/mem_responder.sv
// Main-memory responder: single-beat masked writes, fixed-latency wrapping read bursts.
// Define MEM_RANDOM_STALL_EN to add LFSR-driven request and beat stalls.
module mem_responder #(
  parameter int DATA_BITS    = 128,
  parameter int ADDR_BITS    = 28,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 4,
  parameter int BURST_LEN    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic                   mem_req_rw,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int BW    = $clog2(BURST_LEN);
  localparam int NB    = DATA_BITS / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE, WRITE_DATA, READ_WAIT, READ_BURST
  } state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] base;
  logic [BW-1:0]         k;
  logic [3:0]            lat;
  logic                  ready_q;
  logic                  stall;
  logic                  req_fire;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  unused_addr;

  logic [DATA_BITS-1:0]  mem [DEPTH];

`ifdef MEM_RANDOM_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  end

  assign mem_req_ready = ready_q & ~lfsr[0];
  assign stall         = lfsr[1];
`else
  assign mem_req_ready = ready_q;
  assign stall         = 1'b0;
`endif

  assign req_fire = mem_req_valid & mem_req_ready;

  assign mem_req_data_ready =
    (state == IDLE && mem_req_valid && mem_req_rw) ||
    (state == WRITE_DATA);

  assign wr_en = !reset && mem_req_data_valid &&
    ((state == IDLE && req_fire && mem_req_rw) ||
     (state == WRITE_DATA));

  assign wr_idx = (state == WRITE_DATA) ?
    base : mem_req_addr[DEPTH_LOG2-1:0];

  // Burst offset wraps inside the aligned BURST_LEN block
  assign rd_idx = {base[DEPTH_LOG2-1:BW], base[BW-1:0] + k};

  assign unused_addr = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_req_data_mask[b])
          mem[wr_idx][8*b +: 8] <= mem_req_data_bits[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      base           <= '0;
      k              <= '0;
      lat            <= '0;
      ready_q        <= 1'b0;
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
    end else begin
      ready_q        <= 1'b0;
      mem_resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (req_fire) begin
            if (mem_req_rw) begin
              if (!mem_req_data_valid) begin
                base    <= mem_req_addr[DEPTH_LOG2-1:0];
                ready_q <= 1'b0;
                state   <= WRITE_DATA;
              end
            end else begin
              base    <= mem_req_addr[DEPTH_LOG2-1:0];
              k       <= '0;
              lat     <= 4'(READ_LATENCY);
              ready_q <= 1'b0;
              state   <= (READ_LATENCY == 0) ? READ_BURST : READ_WAIT;
            end
          end
        end
        WRITE_DATA: begin
          if (mem_req_data_valid) state <= IDLE;
        end
        READ_WAIT: begin
          if (lat <= 4'd1) state <= READ_BURST;
          else             lat   <= lat - 4'd1;
        end
        READ_BURST: begin
          if (!stall) begin
            mem_resp_valid <= 1'b1;
            mem_resp_data  <= mem[rd_idx];
            k              <= k + 1'b1;
            if (k == BW'(BURST_LEN - 1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: writes, masks, burst timing,
// wrap order, aliasing and reset during a burst.
module tb_mem_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [27:0]  mem_req_addr;
  logic         mem_req_rw;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  int tests = 0;
  int fails = 0;

  logic [127:0] bd [4];
  logic         rdy [16];
  int           nb, fc, lc;

  mem_responder dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_req_rw         (mem_req_rw),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_req_data_mask  (mem_req_data_mask),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic wait_ready();
    int n = 0;
    while (mem_req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (mem_req_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: ready=%b required 1 within 40 cycles",
               mem_req_ready);
    end
  endtask

  task automatic wr(input logic [27:0] a, input logic [127:0] d,
                    input logic [15:0] m);
    wait_ready();
    mem_req_valid      = 1'b1;
    mem_req_rw         = 1'b1;
    mem_req_addr       = a;
    mem_req_data_valid = 1'b1;
    mem_req_data_bits  = d;
    mem_req_data_mask  = m;
    @(negedge clk);
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_data_valid = 1'b0;
  endtask

  // Issue a read; c=0 is the cycle right after the accepting edge
  task automatic rd(input logic [27:0] a);
    wait_ready();
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = a;
    @(negedge clk);
    mem_req_valid = 1'b0;
    nb = 0;
    fc = -1;
    lc = -1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      rdy[c] = mem_req_ready;
      if (mem_resp_valid === 1'b1) begin
        if (nb < 4) bd[nb] = mem_resp_data;
        nb++;
        if (fc < 0) fc = c;
        lc = c;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (mem_req_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_ready: got %b want 0", mem_req_ready);
    end
    tests++;
    if (mem_resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid: got %b want 0", mem_resp_valid);
    end
    tests++;
    if (mem_resp_data !== 128'h0) begin
      fails++;
      $display("FAIL rst_data: got %h want 0", mem_resp_data);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_release_ready: got %b want 1", mem_req_ready);
    end
  endtask

  task automatic test_write_read();
    logic [127:0] d0;
    d0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    wr(28'h11, 128'hA011, 16'hFFFF);
    wr(28'h12, 128'hA012, 16'hFFFF);
    wr(28'h13, 128'hA013, 16'hFFFF);
    wr(28'h10, d0, 16'hFFFF);
    tests++;
    if (mem_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL wr_ready_next: got %b want 1", mem_req_ready);
    end
    rd(28'h10);
    tests++;
    if (nb != 4) begin
      fails++;
      $display("FAIL wr_rd_beats: got %0d want 4", nb);
    end
    tests++;
    if (bd[0] !== d0) begin
      fails++;
      $display("FAIL wr_rd_beat0: got %h want %h", bd[0], d0);
    end
    tests++;
    if (bd[1] !== 128'hA011 || bd[2] !== 128'hA012 ||
        bd[3] !== 128'hA013) begin
      fails++;
      $display("FAIL wr_rd_beats123: got %h %h %h want a011 a012 a013",
               bd[1], bd[2], bd[3]);
    end
  endtask

  task automatic test_read_latency();
    logic busy;
    wr(28'h20, 128'hA, 16'hFFFF);
    wr(28'h21, 128'hB, 16'hFFFF);
    wr(28'h22, 128'hC, 16'hFFFF);
    wr(28'h23, 128'hD, 16'hFFFF);
    rd(28'h20);
    tests++;
    if (fc != 5 || lc != 8 || nb != 4) begin
      fails++;
      $display("FAIL lat_window: got first=%0d last=%0d n=%0d want 5 8 4",
               fc, lc, nb);
    end
    tests++;
    if (bd[0] !== 128'hA || bd[1] !== 128'hB ||
        bd[2] !== 128'hC || bd[3] !== 128'hD) begin
      fails++;
      $display("FAIL lat_data: got %h %h %h %h want a b c d",
               bd[0], bd[1], bd[2], bd[3]);
    end
    busy = 1'b0;
    for (int c = 0; c <= 8; c++) busy = busy | rdy[c];
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL lat_ready_busy: got %b want 0", busy);
    end
    tests++;
    if (rdy[9] !== 1'b1) begin
      fails++;
      $display("FAIL lat_ready_after: got %b want 1", rdy[9]);
    end
  endtask

  task automatic test_mask();
    logic [127:0] e0, e1;
    e0 = {{96{1'b1}}, 32'h0};
    e1 = {8'hFF, 112'h0, 8'hFF};
    wr(28'h30, {128{1'b1}}, 16'hFFFF);
    wr(28'h30, 128'h0, 16'h000F);
    wr(28'h31, 128'h0, 16'hFFFF);
    wr(28'h31, {128{1'b1}}, 16'h8001);
    rd(28'h30);
    tests++;
    if (bd[0] !== e0) begin
      fails++;
      $display("FAIL mask_low: got %h want %h", bd[0], e0);
    end
    tests++;
    if (bd[1] !== e1) begin
      fails++;
      $display("FAIL mask_ends: got %h want %h", bd[1], e1);
    end
  endtask

  task automatic test_write_data_phase();
    wr(28'h50, 128'hDEAD_0050, 16'hFFFF);
    wr(28'h51, 128'hBEEF_0051, 16'hFFFF);
    wait_ready();
    mem_req_valid      = 1'b1;
    mem_req_rw         = 1'b1;
    mem_req_addr       = 28'h50;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = 128'h5555;
    mem_req_data_mask  = 16'hFFFF;
    @(negedge clk);
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    tests++;
    if (mem_req_data_ready !== 1'b1 || mem_req_ready !== 1'b0) begin
      fails++;
      $display("FAIL wd_enter: got dready=%b ready=%b want 1 0",
               mem_req_data_ready, mem_req_ready);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (mem_req_data_ready !== 1'b1) begin
      fails++;
      $display("FAIL wd_hold: got dready=%b want 1", mem_req_data_ready);
    end
    mem_req_data_valid = 1'b1;
    mem_req_data_bits  = 128'hF00D_0050;
    @(negedge clk);
    mem_req_data_valid = 1'b0;
    tests++;
    if (mem_req_data_ready !== 1'b0) begin
      fails++;
      $display("FAIL wd_exit: got dready=%b want 0", mem_req_data_ready);
    end
    // Stray beat with no request must be dropped
    mem_req_addr       = 28'h51;
    mem_req_rw         = 1'b1;
    mem_req_data_valid = 1'b1;
    mem_req_data_bits  = 128'h0BAD;
    repeat (2) @(negedge clk);
    mem_req_data_valid = 1'b0;
    mem_req_rw         = 1'b0;
    rd(28'h50);
    tests++;
    if (bd[0] !== 128'hF00D_0050) begin
      fails++;
      $display("FAIL wd_commit: got %h want f00d0050", bd[0]);
    end
    tests++;
    if (bd[1] !== 128'hBEEF_0051) begin
      fails++;
      $display("FAIL wd_stray: got %h want beef0051", bd[1]);
    end
  endtask

  task automatic test_unaligned();
    for (int i = 0; i < 4; i++)
      wr(28'h40 + 28'(i), 128'h40 + 128'(i), 16'hFFFF);
    rd(28'h42);
    tests++;
    if (bd[0] !== 128'h42 || bd[1] !== 128'h43 ||
        bd[2] !== 128'h40 || bd[3] !== 128'h41) begin
      fails++;
      $display("FAIL wrap: got %h %h %h %h want 42 43 40 41",
               bd[0], bd[1], bd[2], bd[3]);
    end
  endtask

  task automatic test_alias();
    wr(28'h460, 128'h600D, 16'hFFFF);
    rd(28'h60);
    tests++;
    if (bd[0] !== 128'h600D) begin
      fails++;
      $display("FAIL alias: got %h want 600d", bd[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    wait_ready();
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 28'h20;
    @(negedge clk);
    mem_req_valid = 1'b0;
    repeat (7) @(negedge clk);
    tests++;
    if (mem_resp_valid !== 1'b1 || mem_resp_data !== 128'hC) begin
      fails++;
      $display("FAIL mid_beat2: got v=%b d=%h want 1 c",
               mem_resp_valid, mem_resp_data);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (mem_resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_async_drop: got %b want 0", mem_resp_valid);
    end
    @(negedge clk);
    tests++;
    if (mem_req_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_ready: got %b want 0", mem_req_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_release_ready: got %b want 1", mem_req_ready);
    end
    rd(28'h20);
    tests++;
    if (nb != 4 || fc != 5 || bd[0] !== 128'hA || bd[3] !== 128'hD) begin
      fails++;
      $display("FAIL mid_new_read: got n=%0d first=%0d %h %h want 4 5 a d",
               nb, fc, bd[0], bd[3]);
    end
  endtask

  initial begin
    reset              = 1'b1;
    mem_req_valid      = 1'b0;
    mem_req_addr       = '0;
    mem_req_rw         = 1'b0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;
    test_reset();
    test_write_read();
    test_read_latency();
    test_mask();
    test_write_data_phase();
    test_unaligned();
    test_alias();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
